// File: rtl/reset_conditioner_pkg.sv
// Shared types and constants for the reset conditioner: FSM states,
// counter widths and parameter defaults.
package reset_conditioner_pkg;

    localparam int unsigned CNT_W            = 20;
    localparam int unsigned RST_CNT_W        = 8;
    localparam int unsigned DEBOUNCE_CYC_DEF = 500000;
    localparam int unsigned STRETCH_CYC_DEF  = 1000000;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        RELEASE_DB = 3'd3,
        STRETCH    = 3'd4
    } stateT;

endpackage

// File: rtl/reset_conditioner_if.sv
// Request/response bundle between a reset source and the conditioner.
interface reset_conditioner_if
    import reset_conditioner_pkg::*;
    ;
    logic                 iKEY;
    logic                 iSW_RST;
    logic                 oRST_n;
    logic [RST_CNT_W-1:0] oRST_CNT;

    modport master (output iKEY, output iSW_RST, input oRST_n, input oRST_CNT);
    modport slave  (input iKEY, input iSW_RST, output oRST_n, output oRST_CNT);
endinterface

// File: rtl/reset_conditioner_sync2.sv
// Two-flop synchronizer with a parameterized reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iD,
    output logic oQ
);

    logic meta;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            meta <= RST_VAL;
            oQ   <= RST_VAL;
        end else begin
            meta <= iD;
            oQ   <= meta;
        end
    end

endmodule

// File: rtl/reset_conditioner.sv
// Debounces a push-button and software request into stretched, counted
// active-low reset pulses; emits a power-on pulse after iRST release.
module reset_conditioner
    import reset_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned STRETCH_CYC  = STRETCH_CYC_DEF
) (
    input  logic                iCLK,
    input  logic                iRST,
    reset_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STRETCH_CYC - 1);

    stateT                state;
    stateT                stateNxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cntNxt;
    logic                 keyS;
    logic                 rstNQ;
    logic                 rstNNxt;
    logic                 issue;
    logic [RST_CNT_W-1:0] rstCnt;

    sync2 #(.RST_VAL(1'b1)) uSync (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (bus.iKEY),
        .oQ   (keyS)
    );

    // State register and shared dwell counter
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= STRETCH;
            cnt   <= '0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
        end
    end

    // Next-state logic; the counter restarts on every state change
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        case (state)
            RUN: begin
                if (bus.iSW_RST)  stateNxt = STRETCH;
                else if (!keyS)   stateNxt = PRESS_DB;
            end
            PRESS_DB: begin
                if (keyS)                stateNxt = RUN;
                else if (bus.iSW_RST)    stateNxt = STRETCH;
                else if (cnt == DB_LAST) stateNxt = HELD;
                else                     cntNxt   = cnt + CNT_W'(1);
            end
            HELD: begin
                if (keyS) stateNxt = RELEASE_DB;
            end
            RELEASE_DB: begin
                if (!keyS)               stateNxt = HELD;
                else if (cnt == DB_LAST) stateNxt = STRETCH;
                else                     cntNxt   = cnt + CNT_W'(1);
            end
            STRETCH: begin
                if (bus.iSW_RST)         cntNxt   = '0;
                else if (cnt == ST_LAST) stateNxt = RUN;
                else                     cntNxt   = cnt + CNT_W'(1);
            end
            default: stateNxt = STRETCH;
        endcase
        if (stateNxt != state) cntNxt = '0;
    end

    // Output decode from the next state so oRST_n is a plain flop
    always_comb begin
        rstNNxt = 1'b0;
        issue   = 1'b0;
        if (stateNxt == RUN || stateNxt == PRESS_DB) rstNNxt = 1'b1;
        if ((state == RUN || state == PRESS_DB) &&
            (stateNxt == HELD || stateNxt == STRETCH)) issue = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rstNQ  <= 1'b0;
            rstCnt <= '0;
        end else begin
            rstNQ <= rstNNxt;
            if (issue && rstCnt != {RST_CNT_W{1'b1}}) rstCnt <= rstCnt + RST_CNT_W'(1);
        end
    end

    assign bus.oRST_n   = rstNQ;
    assign bus.oRST_CNT = rstCnt;

endmodule

// File: tb/tb_reset_conditioner.sv
// Directed bench for reset_conditioner: deadline-based reference model
// checked every cycle, plus hand-computed edge/latency expectations.
module tb_reset_conditioner;
    import reset_conditioner_pkg::*;

    localparam int unsigned DB = 8;
    localparam int unsigned ST = 16;
    localparam int M_HIGH = 0;
    localparam int M_HELD = 1;
    localparam int M_STR  = 2;

    logic iCLK = 1'b0;
    logic iRST = 1'b0;

    reset_conditioner_if bus ();

    reset_conditioner #(.DEBOUNCE_CYC(DB), .STRETCH_CYC(ST)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: output is high only in "high" mode; a pulse ends at an
    // absolute edge number, debounce is a run of identical synced samples.
    int   edgeNum = 0;
    int   mMode   = M_STR;
    int   mRun    = 0;
    int   mEnd    = 0;
    int   mCnt    = 0;
    logic mP0     = 1'b1;
    logic mP1     = 1'b1;

    task automatic mResetApply();
        mMode = M_STR;
        mEnd  = edgeNum + int'(ST);
        mCnt  = 0;
        mRun  = 0;
        mP0   = 1'b1;
        mP1   = 1'b1;
    endtask

    task automatic mStep();
        logic ks;
        ks  = mP1;
        mP1 = mP0;
        mP0 = bus.iKEY;
        case (mMode)
            M_HIGH: begin
                if (mRun > 0 && ks) mRun = 0;
                else if (bus.iSW_RST) begin
                    mMode = M_STR; mEnd = edgeNum + int'(ST); mRun = 0;
                    if (mCnt < 255) mCnt++;
                end else if (!ks) begin
                    mRun++;
                    if (mRun == int'(DB) + 1) begin
                        mMode = M_HELD; mRun = 0;
                        if (mCnt < 255) mCnt++;
                    end
                end
            end
            M_HELD: begin
                if (!ks) mRun = 0;
                else begin
                    mRun++;
                    if (mRun == int'(DB) + 1) begin
                        mMode = M_STR; mEnd = edgeNum + int'(ST); mRun = 0;
                    end
                end
            end
            default: begin
                if (bus.iSW_RST) mEnd = edgeNum + int'(ST);
                else if (edgeNum == mEnd) begin
                    mMode = M_HIGH; mRun = 0;
                end
            end
        endcase
    endtask

    // Model advances on the rising edge, outputs compared on the falling edge
    initial begin
        forever begin
            @(posedge iCLK);
            edgeNum++;
            if (!iRST) mResetApply();
            else       mStep();
            @(negedge iCLK);
            if (!iRST) mResetApply();
            check("cyc_rstN", int'(bus.oRST_n), int'(mMode == M_HIGH));
            check("cyc_rstCnt", int'(bus.oRST_CNT), mCnt);
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic doReset(input string tag);
        int rise;
        iRST = 1'b0;
        bus.iKEY = 1'b1;
        bus.iSW_RST = 1'b0;
        repeat (3) step();
        check({tag, "_rstN_in_reset"}, int'(bus.oRST_n), 0);
        check({tag, "_cnt_in_reset"}, int'(bus.oRST_CNT), 0);
        iRST = 1'b1;
        rise = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (rise < 0 && bus.oRST_n) rise = k;
        end
        check({tag, "_poweron_rise_edge"}, rise, 16);
        check({tag, "_poweron_cnt"}, int'(bus.oRST_CNT), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall;
        int rise;
        int fall2;
        int low;
        bus.iKEY = 1'b1;
        bus.iSW_RST = 1'b0;

        // Power-on pulse
        doReset("por");

        // Clean press: low 20 edges, then released
        bus.iKEY = 1'b0;
        fall = -1; rise = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 20) bus.iKEY = 1'b1;
            if (fall < 0 && !bus.oRST_n) fall = k;
            if (fall > 0 && rise < 0 && bus.oRST_n) rise = k;
        end
        check("press_fall_edge", fall, 11);
        check("press_rise_edge", rise, 47);
        check("press_cnt", int'(bus.oRST_CNT), 1);

        // Bouncing key: 5 low / 1 high never qualifies
        doReset("bounce");
        low = 0;
        for (int r = 0; r < 12; r++) begin
            bus.iKEY = 1'b0;
            for (int k = 0; k < 5; k++) begin
                step();
                if (!bus.oRST_n) low++;
            end
            bus.iKEY = 1'b1;
            step();
            if (!bus.oRST_n) low++;
        end
        repeat (10) step();
        check("bounce_low_cycles", low, 0);
        check("bounce_cnt", int'(bus.oRST_CNT), 0);

        // Two software pulses 10 cycles apart merge into one 26-cycle reset
        doReset("sw");
        bus.iSW_RST = 1'b1;
        low = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            bus.iSW_RST = (k == 10);
            if (!bus.oRST_n) low++;
        end
        check("sw_low_cycles", low, 26);
        check("sw_cnt", int'(bus.oRST_CNT), 1);

        // Software reset during press debounce; held key re-debounced after RUN
        doReset("swpress");
        bus.iKEY = 1'b0;
        fall = -1; rise = -1; fall2 = -1;
        for (int k = 1; k <= 50; k++) begin
            step();
            bus.iSW_RST = (k == 4);
            if (fall < 0 && !bus.oRST_n) fall = k;
            else if (fall > 0 && rise < 0 && bus.oRST_n) rise = k;
            else if (rise > 0 && fall2 < 0 && !bus.oRST_n) fall2 = k;
        end
        check("swpress_fall_edge", fall, 5);
        check("swpress_rise_edge", rise, 21);
        check("swpress_refall_edge", fall2, 30);
        check("swpress_cnt", int'(bus.oRST_CNT), 2);

        // iRST while HELD aborts and restarts with an uncounted power-on pulse
        doReset("held");
        bus.iKEY = 1'b0;
        repeat (15) step();
        check("held_rstN", int'(bus.oRST_n), 0);
        check("held_cnt", int'(bus.oRST_CNT), 1);
        doReset("held_abort");

        // Counter saturation
        for (int i = 1; i <= 260; i++) begin
            bus.iSW_RST = 1'b1;
            step();
            bus.iSW_RST = 1'b0;
            repeat (17) step();
            if (i == 254) check("sat_cnt_254", int'(bus.oRST_CNT), 254);
        end
        check("sat_cnt_final", int'(bus.oRST_CNT), 255);
        check("sat_rstN_final", int'(bus.oRST_n), 1);

        repeat (2) step();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/reset_conditioner.md
RESET_CONDITIONER -- requirements
Module: reset_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 500000, consecutive stable synced-key cycles required; legal range 2..2^20-1.
REQ-002 SHALL have parameter STRETCH_CYC, default 1000000, length in cycles of every issued reset pulse; legal range 2..2^20-1.
REQ-003 SHALL have port iCLK  input  1  system clock (50 MHz nominal).
REQ-004 SHALL have port iRST  input  1  reset, asynchronous, active-low; clock iCLK.
REQ-005 SHALL have port iKEY  input  1  raw push-button, active-low, asynchronous, bouncing.
REQ-006 SHALL have port iSW_RST  input  1  software reset request, synchronous to iCLK, active-high, level-sampled.
REQ-007 SHALL have port oRST_n  output  1  conditioned active-low reset feeding the staggered reset-delay stage.
REQ-008 SHALL have port oRST_CNT  output  8  count of resets issued since iRST.

Function
REQ-009 SHALL pass iKEY through a 2-flop synchronizer whose flops reset to 1 (released); all decisions use its output key_s.
REQ-010 SHALL implement states RUN, PRESS_DB, HELD, RELEASE_DB, STRETCH, with one 20-bit counter cnt cleared on every state change.
REQ-011 RUN: oRST_n=1; iSW_RST=1 -> STRETCH (priority); else key_s=0 -> PRESS_DB.
REQ-012 PRESS_DB: oRST_n=1; key_s=1 -> RUN; iSW_RST=1 -> STRETCH; key_s=0 with cnt=DEBOUNCE_CYC-1 -> HELD; else cnt+1.
REQ-013 HELD: oRST_n=0; key_s=1 -> RELEASE_DB; iSW_RST ignored.
REQ-014 RELEASE_DB: oRST_n=0; key_s=0 -> HELD; key_s=1 with cnt=DEBOUNCE_CYC-1 -> STRETCH; else cnt+1; iSW_RST ignored.
REQ-015 STRETCH: oRST_n=0; iSW_RST=1 -> cnt restarts at 0; key_s ignored; cnt=STRETCH_CYC-1 -> RUN; else cnt+1.
REQ-016 oRST_n SHALL be a registered output, driven 0 in HELD/RELEASE_DB/STRETCH and 1 in RUN/PRESS_DB, with no combinational path from any input.
REQ-017 Press latency: key held low from sampling edge 1 -> oRST_n falls at edge DEBOUNCE_CYC+3.
REQ-018 STRETCH entry -> oRST_n low for exactly STRETCH_CYC cycles, absent further iSW_RST.
REQ-019 oRST_CNT SHALL increment on every RUN->STRETCH or PRESS_DB->HELD/STRETCH transition (each 1->0 of oRST_n), saturating at 255.
REQ-020 Key pressed while in STRETCH SHALL be debounced afresh only after return to RUN.

Reset
REQ-021 iRST=0 SHALL asynchronously force oRST_n=0, oRST_CNT=0, synchronizer=1, cnt=0, state=STRETCH.
REQ-022 After iRST release, the block SHALL emit a power-on pulse of STRETCH_CYC cycles, not counted in oRST_CNT.
REQ-023 iRST asserted mid-operation in any state SHALL abort it and restart per REQ-021/022.

Structure
REQ-024 Package reset_conditioner_pkg SHALL hold the state enum, counter width constant (20) and parameter defaults.
REQ-025 The synchronizer SHALL be sub-module sync2 (2 flops, parameterized reset value), instantiated once.

Verification (DEBOUNCE_CYC=8, STRETCH_CYC=16)
REQ-026 Release iRST, iKEY=1 -> oRST_n=0 for 16 cycles then 1; oRST_CNT=0.
REQ-027 iKEY low 20 cycles then high -> oRST_n falls at edge 11, rises 16 cycles after release debounce completes; oRST_CNT=1.
REQ-028 iKEY bounces 5 cycles low / 1 high repeatedly -> oRST_n stays 1, oRST_CNT=0.
REQ-029 iSW_RST 1-cycle pulse in RUN, second pulse 10 cycles later -> oRST_n low 26 cycles total; oRST_CNT=1.
REQ-030 260 iSW_RST-triggered resets -> oRST_CNT saturates at 255.
REQ-031 iRST asserted during HELD -> oRST_n stays 0, oRST_CNT=0, power-on pulse of 16 cycles after release.
